// File: rtl/alarm_keypad_if.sv
// Signal bundle between the keypad front end and alarm_keypad.
// Key and command strobes go in; arm status and result pulses come out.
interface alarm_keypad_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       cmd_away;
  logic       cmd_stay;
  logic       cmd_off;
  logic       alarm_set;
  logic       alarm_stay;
  logic       exiting;
  logic       locked;
  logic       code_ok;
  logic       bad_code;

  modport master (
    output key_valid, key_digit, cmd_away, cmd_stay, cmd_off,
    input  alarm_set, alarm_stay, exiting, locked, code_ok, bad_code
  );

  modport slave (
    input  key_valid, key_digit, cmd_away, cmd_stay, cmd_off,
    output alarm_set, alarm_stay, exiting, locked, code_ok, bad_code
  );
endinterface

// File: rtl/alarm_keypad.sv
// Keypad code checker and arm/disarm FSM with an exit delay.
// Define LOCKOUT_EN to add the failed-attempt keypad lockout.
module alarm_keypad #(
  parameter logic [15:0] CODE     = 16'h1234,
  parameter int          EXIT_DLY = 8,
  parameter int          MAX_FAIL = 3,
  parameter int          LOCK_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alarm_keypad_if.slave kp
);

  typedef enum logic [1:0] {DISARMED, EXIT, ARMED} state_t;

  localparam logic [7:0] EXIT_LOAD = 8'(EXIT_DLY);

  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  count_q, count_d;
  logic        stay_q, stay_d;
  logic [7:0]  exit_cnt_q, exit_cnt_d;
  logic        ok_q, ok_d;
  logic        bad_q, bad_d;
  logic        set_q, set_d;
  logic        astay_q, astay_d;
  logic        exiting_q, exiting_d;
  logic        cmd_any;
  logic        match;
  logic        lock_active;

  assign cmd_any = kp.cmd_off | kp.cmd_away | kp.cmd_stay;
  assign match   = (count_q == 3'd4) && (buf_q == CODE);

`ifdef LOCKOUT_EN
  localparam logic [2:0] FAIL_LIM  = 3'(MAX_FAIL);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYC);

  logic [2:0] fail_q, fail_d;
  logic [7:0] lock_q, lock_d;

  assign lock_active = (lock_q != 8'd0);

  // Lockout entry is keyed off the same-cycle result pulse, so the
  // command that trips it is still reported as bad_code.
  always_comb begin
    fail_d = fail_q;
    lock_d = lock_q;
    if (lock_active) begin
      lock_d = lock_q - 8'd1;
    end else if (ok_d) begin
      fail_d = 3'd0;
    end else if (bad_d) begin
      if (fail_q + 3'd1 == FAIL_LIM) begin
        fail_d = 3'd0;
        lock_d = LOCK_LOAD;
      end else begin
        fail_d = fail_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= 3'd0;
      lock_q <= 8'd0;
    end else begin
      fail_q <= fail_d;
      lock_q <= lock_d;
    end
  end
`else
  // Lockout compiled out; constant 0 for any legal MAX_FAIL/LOCK_CYC.
  assign lock_active = (MAX_FAIL == 0) && (LOCK_CYC == 0);
`endif

  // While locked nothing moves, including a running exit countdown.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    stay_d     = stay_q;
    exit_cnt_d = exit_cnt_q;
    ok_d       = 1'b0;
    bad_d      = 1'b0;
    if (!lock_active) begin
      if (cmd_any) begin
        buf_d   = 16'h0000;
        count_d = 3'd0;
        if (kp.cmd_off) begin
          if (match) begin
            ok_d       = 1'b1;
            state_d    = DISARMED;
            stay_d     = 1'b0;
            exit_cnt_d = 8'd0;
          end else begin
            bad_d = 1'b1;
          end
        end else if (state_q == DISARMED) begin
          if (match) begin
            ok_d       = 1'b1;
            state_d    = EXIT;
            stay_d     = ~kp.cmd_away;
            exit_cnt_d = EXIT_LOAD;
          end else begin
            bad_d = 1'b1;
          end
        end
      end else if (kp.key_valid && (kp.key_digit <= 4'd9)) begin
        buf_d = {buf_q[11:0], kp.key_digit};
        if (count_q != 3'd4) begin
          count_d = count_q + 3'd1;
        end
      end
      if ((state_q == EXIT) && (state_d == EXIT)) begin
        exit_cnt_d = exit_cnt_q - 8'd1;
        if (exit_cnt_q == 8'd1) begin
          state_d = ARMED;
        end
      end
    end
    set_d     = (state_d == ARMED);
    astay_d   = (state_d == ARMED) && stay_d;
    exiting_d = (state_d == EXIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DISARMED;
      buf_q      <= 16'h0000;
      count_q    <= 3'd0;
      stay_q     <= 1'b0;
      exit_cnt_q <= 8'd0;
      ok_q       <= 1'b0;
      bad_q      <= 1'b0;
      set_q      <= 1'b0;
      astay_q    <= 1'b0;
      exiting_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      stay_q     <= stay_d;
      exit_cnt_q <= exit_cnt_d;
      ok_q       <= ok_d;
      bad_q      <= bad_d;
      set_q      <= set_d;
      astay_q    <= astay_d;
      exiting_q  <= exiting_d;
    end
  end

  assign kp.alarm_set  = set_q;
  assign kp.alarm_stay = astay_q;
  assign kp.exiting    = exiting_q;
  assign kp.locked     = lock_active;
  assign kp.code_ok    = ok_q;
  assign kp.bad_code   = bad_q;

endmodule

// File: tb/tb_alarm_keypad.sv
// Scoreboard bench for alarm_keypad: directed scenarios plus random keypad
// traffic, checked every cycle against a behavioural model of the keypad.
module tb_alarm_keypad;

  localparam logic [15:0] CODE     = 16'h1234;
  localparam int          EXIT_DLY = 8;
  localparam int          MAX_FAIL = 3;
  localparam int          LOCK_CYC = 16;

  typedef struct packed {
    logic a_set;
    logic a_stay;
    logic exiting;
    logic locked;
    logic ok;
    logic bad;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  // Reference model: what the keypad owner would observe.
  int digits[$];
  int exit_left = 0;
  bit is_armed = 1'b0;
  bit stay_mode = 1'b0;
  int fails = 0;
  int lock_left = 0;

  alarm_keypad_if kp();

  alarm_keypad #(
    .CODE    (CODE),
    .EXIT_DLY(EXIT_DLY),
    .MAX_FAIL(MAX_FAIL),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  function automatic int code_digit(input int i);
    logic [15:0] c;
    c = CODE;
    return int'(c[15-4*i -: 4]);
  endfunction

  function automatic bit code_entered();
    if (digits.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (digits[i] != code_digit(i)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    digits.delete();
    exit_left = 0;
    is_armed  = 1'b0;
    stay_mode = 1'b0;
    fails     = 0;
    lock_left = 0;
  endfunction

  function automatic exp_t model_step(input bit kv, input logic [3:0] kd,
                                      input bit away, input bit stay, input bit off);
    exp_t r;
    bit ok = 1'b0;
    bit nok = 1'b0;
    bit loaded = 1'b0;
    if (lock_left > 0) begin
      lock_left--;
    end else begin
      if (away || stay || off) begin
        bit m;
        m = code_entered();
        digits.delete();
        if (off) begin
          if (m) begin
            ok = 1'b1;
            is_armed = 1'b0;
            exit_left = 0;
            stay_mode = 1'b0;
          end else begin
            nok = 1'b1;
          end
        end else if (!is_armed && exit_left == 0) begin
          if (m) begin
            ok = 1'b1;
            exit_left = EXIT_DLY;
            stay_mode = !away;
            loaded = 1'b1;
          end else begin
            nok = 1'b1;
          end
        end
      end else if (kv && kd < 4'd10) begin
        digits.push_back(int'(kd));
        if (digits.size() > 4) void'(digits.pop_front());
      end
      if (exit_left > 0 && !loaded) begin
        exit_left--;
        if (exit_left == 0) is_armed = 1'b1;
      end
`ifdef LOCKOUT_EN
      if (ok) begin
        fails = 0;
      end else if (nok) begin
        fails++;
        if (fails == MAX_FAIL) begin
          fails = 0;
          lock_left = LOCK_CYC;
          digits.delete();
        end
      end
`endif
    end
    r.a_set   = is_armed;
    r.a_stay  = is_armed && stay_mode;
    r.exiting = (exit_left > 0);
    r.locked  = (lock_left > 0);
    r.ok      = ok;
    r.bad     = nok;
    return r;
  endfunction

  task automatic apply_stimulus(input bit kv, input logic [3:0] kd,
                                input bit away, input bit stay, input bit off);
    @(negedge clk);
    kp.key_valid = kv;
    kp.key_digit = kd;
    kp.cmd_away  = away;
    kp.cmd_stay  = stay;
    kp.cmd_off   = off;
    exp_q.push_back(model_step(kv, kd, away, stay, off));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input int wrong_pos);
    for (int i = 0; i < 4; i++) begin
      int d;
      d = code_digit(i);
      if (i == wrong_pos) d = (d + 1) % 10;
      apply_stimulus(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_output(input exp_t e);
    exp_t act;
    act = {kp.alarm_set, kp.alarm_stay, kp.exiting, kp.locked, kp.code_ok, kp.bad_code};
    total++;
    if (act !== e) begin
      bad++;
      $display("[TB] FAIL outputs t=%0t: got set/stay/exit/lock/ok/bad=%b%b%b%b%b%b want %b%b%b%b%b%b",
               $time, act.a_set, act.a_stay, act.exiting, act.locked, act.ok, act.bad,
               e.a_set, e.a_stay, e.exiting, e.locked, e.ok, e.bad);
    end
  endtask

  task automatic check_reset();
    exp_t zero;
    exp_t act;
    zero = '0;
    act = {kp.alarm_set, kp.alarm_stay, kp.exiting, kp.locked, kp.code_ok, kp.bad_code};
    total++;
    if (act !== zero) begin
      bad++;
      $display("[TB] FAIL reset t=%0t: got outputs %b want %b", $time, act, zero);
    end
  endtask

  // Asserted between edges so the check sees the asynchronous clear.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    kp.key_valid = 1'b0;
    kp.cmd_away  = 1'b0;
    kp.cmd_stay  = 1'b0;
    kp.cmd_off   = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    kp.key_valid = 1'b0;
    kp.key_digit = 4'd0;
    kp.cmd_away  = 1'b0;
    kp.cmd_stay  = 1'b0;
    kp.cmd_off   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle(2);
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(EXIT_DLY + 2);
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(2);

    apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(EXIT_DLY + 2);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'(code_digit(i)), 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    idle(3);

    enter_code(-1);
    apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'(code_digit(i)), 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'(code_digit(3)), 1'b1, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < MAX_FAIL; i++) begin
      enter_code(3);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(LOCK_CYC);
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    do_reset();
    enter_code(-1);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int e = 0; e < 300; e++) begin
      int kind;
      int cmd;
      kind = $urandom_range(0, 9);
      cmd  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : (1 << $urandom_range(0, 2));
      case (kind)
        0, 1, 2, 3, 4: begin
          if ($urandom_range(0, 3) == 0) apply_stimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
          enter_code(($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1);
          apply_stimulus(1'b0, 4'd0, cmd[1], cmd[2], cmd[0]);
        end
        5, 6: begin
          int n;
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) apply_stimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        end
        7: apply_stimulus(1'b0, 4'd0, cmd[1], cmd[2], cmd[0]);
        8: idle($urandom_range(0, 12));
        default: apply_stimulus(1'b1, 4'($urandom_range(0, 15)), cmd[1], cmd[2], cmd[0]);
      endcase
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    idle(EXIT_DLY + LOCK_CYC + 4);
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_keypad.md
ALARM_KEYPAD -- requirements
Module: alarm_keypad

Interface
REQ-001 Parameter CODE, default 16'h1234, four-digit arming code as BCD digits, most significant digit entered first.
REQ-002 Parameter EXIT_DLY, default 8, exit-delay length in clock cycles (range 1..255).
REQ-003 Parameter MAX_FAIL, default 3, consecutive failed commands that trigger lockout (range 1..7).
REQ-004 Parameter LOCK_CYC, default 16, lockout length in clock cycles (range 1..255).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 key_valid  input  1  one-cycle strobe; key_digit is valid.
REQ-008 key_digit  input  4  BCD digit 0..9; values 10..15 are discarded.
REQ-009 cmd_away  input  1  one-cycle arm-away request (doors and windows monitored).
REQ-010 cmd_stay  input  1  one-cycle arm-stay request (windows only monitored).
REQ-011 cmd_off  input  1  one-cycle disarm request.
REQ-012 alarm_set  output  1  arm enable to the alarm block.
REQ-013 alarm_stay  output  1  stay-mode select to the alarm block.
REQ-014 exiting  output  1  exit delay in progress.
REQ-015 locked  output  1  keypad lockout active.
REQ-016 code_ok  output  1  one-cycle pulse: command accepted.
REQ-017 bad_code  output  1  one-cycle pulse: command rejected.

Function
REQ-018 Digit buffer: 4-digit shift register plus count 0..4; each valid digit shifts in, count saturates at 4, and the oldest digit drops off.
REQ-019 Match: count==4 and buffer==CODE; any command cycle clears buffer and count.
REQ-020 Command priority in one cycle: cmd_off > cmd_away > cmd_stay; the lower-priority commands are ignored.
REQ-021 key_valid coincident with a command: command evaluates the pre-existing buffer; the digit is discarded.
REQ-022 FSM states DISARMED, EXIT, ARMED.
REQ-023 DISARMED + cmd_away/cmd_stay + match -> EXIT; stay flag latched (1 for cmd_stay); exit counter loaded with EXIT_DLY; code_ok pulses.
REQ-024 EXIT: exiting=1, alarm_set=0; counter decrements each cycle; on the cycle it reaches 0 -> ARMED.
REQ-025 ARMED: alarm_set=1, alarm_stay=stay flag, exiting=0.
REQ-026 cmd_off + match in EXIT or ARMED -> DISARMED next cycle, stay flag cleared, code_ok pulses.
REQ-027 cmd_away/cmd_stay in EXIT or ARMED: ignored, with no pulse and no fail count.
REQ-028 cmd_off in DISARMED with match: code_ok pulses and the state is unchanged.
REQ-029 Any evaluated command without a match, including count<4: bad_code pulses and the state is unchanged.
REQ-030 Pulses are registered and appear the cycle after the command; alarm_set, alarm_stay and exiting are registered outputs of the FSM.
REQ-031 In DISARMED and EXIT, alarm_stay=0.

Reset
REQ-032 rst_n low: state DISARMED, buffer 0, count 0, stay flag 0, counters 0, all outputs 0, immediately and independent of clk.
REQ-033 Reset mid-EXIT or mid-lockout abandons the operation; no pulse is emitted after release.

Configuration
REQ-034 With LOCKOUT_EN defined: a fail counter increments on bad_code and clears on code_ok. On reaching MAX_FAIL it clears, locked=1 for LOCK_CYC cycles, and commands and digits are ignored without pulses. The FSM state is held, so an armed system stays armed. The buffer is cleared on lockout entry.
REQ-035 Without LOCKOUT_EN: no fail or lockout logic, locked tied to 0, and failures have no effect beyond bad_code.

Verification
REQ-036 Digits 1,2,3,4 then cmd_away -> code_ok; exiting=1 for 8 cycles; then alarm_set=1, alarm_stay=0.
REQ-037 Digits 9,1,2,3,4 then cmd_stay -> code_ok, then alarm_set=1, alarm_stay=1; next 1,2,3,4 and cmd_off -> alarm_set=0.
REQ-038 Digits 1,2,3 then cmd_away -> bad_code, state DISARMED; cmd_off+cmd_away in the same cycle with a valid code -> disarm path only.
REQ-039 LOCKOUT_EN: three wrong codes -> locked=1 for 16 cycles, correct code plus cmd_away ignored during lockout and accepted after it.
REQ-040 rst_n low during EXIT -> all outputs 0 immediately; after release, cmd_off with a valid code -> code_ok and state DISARMED.
